// File: rtl/calc_operand_fsm.sv
// Serial front-end for the 8-bit calculator: collects A, operator and B,
// then registers the result and error flag. Division comes from an external divider.
module calc_operand_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] div_dividend,
  output logic [7:0] div_divisor,
  input  logic [7:0] div_quotient,
  input  logic       div_error,
  output logic [7:0] result,
  output logic       error,
  output logic       result_valid,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_OP = 3'd1,
    WAIT_B  = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  result_q, result_d;
  logic        error_q, error_d;
  logic        result_valid_q, result_valid_d;

  logic [8:0]  sum_w;
  logic [8:0]  diff_w;
  logic [15:0] prod_w;
  logic [7:0]  exec_result;
  logic        exec_error;
  logic        accept;

  assign in_ready = (state_q == WAIT_A) || (state_q == WAIT_OP) ||
                    (state_q == WAIT_B) || (state_q == DONE);
  assign busy     = (state_q == EXEC);
  assign state    = state_q;
  assign accept   = in_valid && in_ready;

  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign result       = result_q;
  assign error        = error_q;
  assign result_valid = result_valid_q;

  always_comb begin
    sum_w       = {1'b0, a_q} + {1'b0, b_q};
    diff_w      = {1'b0, a_q} - {1'b0, b_q};
    prod_w      = {8'd0, a_q} * {8'd0, b_q};
    exec_result = 8'd0;
    exec_error  = 1'b0;
    case (op_q)
      2'b00: begin
        exec_result = sum_w[7:0];
        exec_error  = sum_w[8];
      end
      2'b01: begin
        // Bit 8 of the zero-extended difference is the borrow (A < B).
        exec_result = diff_w[7:0];
        exec_error  = diff_w[8];
      end
      2'b10: begin
        exec_result = prod_w[7:0];
        exec_error  = |prod_w[15:8];
      end
      default: begin
        exec_result = div_error ? 8'd0 : div_quotient;
        exec_error  = div_error;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    result_d       = result_q;
    error_d        = error_q;
    result_valid_d = 1'b0;

    if (clear) begin
      state_d  = WAIT_A;
      a_d      = 8'd0;
      b_d      = 8'd0;
      op_d     = 2'd0;
      result_d = 8'd0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_A, DONE: begin
          if (accept) begin
            a_d     = in_data;
            state_d = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (accept) begin
            op_d    = in_data[1:0];
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (accept) begin
            b_d     = in_data;
            state_d = EXEC;
          end
        end
        EXEC: begin
          result_d       = exec_result;
          error_d        = exec_error;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_A;
      a_q            <= 8'd0;
      b_q            <= 8'd0;
      op_q           <= 2'd0;
      result_q       <= 8'd0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      result_q       <= result_d;
      error_q        <= error_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule
